// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO behind a UART receiver, pushes on dvalid rising edge, drains on a valid/ready stream
// clk       system clock
// nreset    asynchronous active-low reset
// rx_data   received byte, stable while dvalid is high
// dvalid    receiver byte-valid level, a new byte is its rising edge
// m_data    head byte, 8'h00 while empty
// m_valid   fifo non-empty
// m_ready   consumer takes the head byte on m_valid & m_ready
// level     entry count 0..2**DEPTH_LOG2
// overflow  sticky flag, a byte was dropped on full
// clr_ovf   synchronous clear of overflow
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [7:0]            rx_data,
    input  logic                  dvalid,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clr_ovf
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  dvalid_d;
    logic                  push_req;
    logic                  pop;
    logic                  accept;
    logic                  drop;
    // dvalid_d resets high so a dvalid already asserted at reset release is not a new byte
    assign push_req = dvalid & ~dvalid_d;
    assign m_valid  = level != '0;
    assign pop      = m_valid & m_ready;
    // a simultaneous pop frees the slot, so a full fifo still accepts
    assign accept   = push_req & ((level != FULL) | pop);
    assign drop     = push_req & ~accept;
    assign m_data   = m_valid ? mem[rd_ptr] : 8'h00;
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= rx_data;
    end
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            dvalid_d <= 1'b1;
        end else begin
            dvalid_d <= dvalid;
            wr_ptr   <= accept ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
            level    <= (accept & ~pop) ? level + 1'b1 :
                        (pop & ~accept) ? level - 1'b1 : level;
            overflow <= drop | (overflow & ~clr_ovf);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and scoreboarded checks of uart_rx_fifo
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       nreset;
    logic [7:0] rx_data;
    logic       dvalid;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] level;
    logic       overflow;
    logic       clr_ovf;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .nreset(nreset), .rx_data(rx_data), .dvalid(dvalid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [7:0] b);
        rx_data = b;
        dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        tick();
    endtask
    task automatic pop_one(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(m_valid), 1);
        chk({tag, "_data"}, 32'(m_data), 32'(exp));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic pop_now;
        nreset = 1'b0;
        dvalid = 1'b1;
        rx_data = 8'h5A;
        m_ready = 1'b0;
        clr_ovf = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        nreset = 1'b1;
        repeat (3) tick();
        chk("t1_nopush_level", 32'(level), 0);
        chk("t1_nopush_valid", 32'(m_valid), 0);
        dvalid = 1'b0;
        tick();
        rx_data = 8'hA5;
        dvalid = 1'b1;
        tick();
        chk("t1_valid", 32'(m_valid), 1);
        chk("t1_data", 32'(m_data), 32'hA5);
        chk("t1_level", 32'(level), 1);
        dvalid = 1'b0;
        tick();
        pop_one("t1_pop", 8'hA5);
        chk("t1_empty", 32'(level), 0);
        rx_data = 8'h3C;
        dvalid = 1'b1;
        repeat (50) tick();
        dvalid = 1'b0;
        tick();
        chk("t2_level", 32'(level), 1);
        pop_one("t2_pop", 8'h3C);
        chk("t2_empty", 32'(m_valid), 0);
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t3_full", 32'(level), 16);
        chk("t3_ovf0", 32'(overflow), 0);
        push(8'hFF);
        chk("t3_drop_level", 32'(level), 16);
        chk("t3_ovf1", 32'(overflow), 1);
        for (int i = 0; i < 16; i++) pop_one("t3_drain", 8'(i));
        chk("t3_empty_valid", 32'(m_valid), 0);
        chk("t3_empty_data", 32'(m_data), 0);
        chk("t3_empty_level", 32'(level), 0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        rx_data = 8'h77;
        dvalid = 1'b1;
        m_ready = 1'b1;
        tick();
        dvalid = 1'b0;
        m_ready = 1'b0;
        chk("t4_level", 32'(level), 16);
        chk("t4_head", 32'(m_data), 32'h11);
        chk("t4_ovf", 32'(overflow), 0);
        tick();
        for (int i = 1; i < 16; i++) pop_one("t4_drain", 8'(8'h10 + i));
        pop_one("t4_last", 8'h77);
        chk("t4_ovf_end", 32'(overflow), 0);
        chk("t4_empty", 32'(level), 0);
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        push(8'hEE);
        chk("t5_ovf_set", 32'(overflow), 1);
        rx_data = 8'hEF;
        dvalid = 1'b1;
        clr_ovf = 1'b1;
        tick();
        dvalid = 1'b0;
        clr_ovf = 1'b0;
        chk("t5_drop_wins", 32'(overflow), 1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t5_clr_alone", 32'(overflow), 0);
        chk("t5_level", 32'(level), 16);
        for (int i = 0; i < 16; i++) pop_one("t5_drain", 8'(8'h20 + i));
        for (int i = 0; i < 40; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                rx_data = 8'($urandom);
                dvalid = (ph == 0);
                m_ready = 1'($urandom_range(0, 1));
                pop_now = m_valid & m_ready;
                chk("t6_level", 32'(level), 32'(sb.size()));
                if (pop_now) begin
                    chk("t6_data", 32'(m_data), 32'(sb[0]));
                    void'(sb.pop_front());
                end
                if (ph == 0 && (sb.size() < 16 || pop_now)) sb.push_back(rx_data);
                tick();
            end
        end
        dvalid = 1'b0;
        m_ready = 1'b0;
        if (sb.size() == 0) begin
            push(8'h99);
            sb.push_back(8'h99);
        end
        chk("t6_nonempty", 32'(m_valid), 1);
        chk("t6_head", 32'(m_data), 32'(sb[0]));
        nreset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_valid), 0);
        chk("t6_rst_level", 32'(level), 0);
        chk("t6_rst_data", 32'(m_data), 0);
        tick();
        nreset = 1'b1;
        tick();
        push(8'h42);
        pop_one("t6_after_rst", 8'h42);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
